// File: rtl/mux_1_3_deadlock_reporter_if.sv
// Report-side bundle of the mux_1_3 deadlock reporter: monitor inputs, clear,
// and the valid/ready deadlock report with its payload.
interface mux_1_3_deadlock_reporter_if #(
  parameter int CNT_W = 16
);
  logic             block;
  logic [3:0]       axis_block_sigs;
  logic             clear;
  logic             report_valid;
  logic             report_ready;
  logic [3:0]       report_cause;
  logic [CNT_W-1:0] report_cycles;
  logic             deadlock;

  // Master: the environment (monitor, software, report consumer).
  modport master (
    output block, axis_block_sigs, clear, report_ready,
    input  report_valid, report_cause, report_cycles, deadlock
  );

  // Slave: the reporter block itself.
  modport slave (
    input  block, axis_block_sigs, clear, report_ready,
    output report_valid, report_cause, report_cycles, deadlock
  );
endinterface

// File: rtl/mux_1_3_deadlock_reporter.sv
// Filters the mux_1_3 monitor's block flag for THRESHOLD consecutive cycles,
// then emits a one-shot cause report and holds a sticky deadlock level.
module mux_1_3_deadlock_reporter #(
  parameter int THRESHOLD = 1024,
  parameter int CNT_W     = 16
) (
  input logic                        clock,
  input logic                        reset,
  mux_1_3_deadlock_reporter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    REPORT,
    HOLD
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(THRESHOLD - 1);
  localparam logic [CNT_W-1:0] REPORT_LEN = CNT_W'(THRESHOLD);

  state_e           state_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [3:0]       cause_acc_q;
  logic             report_valid_q;
  logic             deadlock_q;
  logic [3:0]       report_cause_q;
  logic [CNT_W-1:0] report_cycles_q;

  // Cause set including the channels blocked in the current sample.
  logic [3:0]       cause_d;
  assign cause_d = cause_acc_q | bus.axis_block_sigs;

  // NOTE: all state and outputs update with <= in one clocked block, so every
  // output is a flop and no input reaches an output combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      run_cnt_q       <= '0;
      cause_acc_q     <= '0;
      report_valid_q  <= 1'b0;
      deadlock_q      <= 1'b0;
      report_cause_q  <= '0;
      report_cycles_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.block) begin
            run_cnt_q   <= CNT_W'(1);
            cause_acc_q <= bus.axis_block_sigs;
            state_q     <= COUNT;
          end else begin
            run_cnt_q   <= '0;
            cause_acc_q <= '0;
          end
        end

        COUNT: begin
          if (!bus.block) begin
            // A single low sample discards the whole run.
            run_cnt_q   <= '0;
            cause_acc_q <= '0;
            state_q     <= IDLE;
          end else if (run_cnt_q == LAST_CNT) begin
            report_cause_q  <= cause_d;
            report_cycles_q <= REPORT_LEN;
            report_valid_q  <= 1'b1;
            deadlock_q      <= 1'b1;
            run_cnt_q       <= '0;
            cause_acc_q     <= '0;
            state_q         <= REPORT;
          end else begin
            run_cnt_q   <= run_cnt_q + CNT_W'(1);
            cause_acc_q <= cause_d;
          end
        end

        REPORT: begin
          // Payload stays frozen; block and clear are ignored until accepted.
          if (bus.report_ready) begin
            report_valid_q <= 1'b0;
            state_q        <= HOLD;
          end
        end

        HOLD: begin
          if (bus.clear) begin
            deadlock_q      <= 1'b0;
            report_cause_q  <= '0;
            report_cycles_q <= '0;
            state_q         <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.report_valid  = report_valid_q;
  assign bus.deadlock      = deadlock_q;
  assign bus.report_cause  = report_cause_q;
  assign bus.report_cycles = report_cycles_q;

endmodule

// File: tb/tb_mux_1_3_deadlock_reporter.sv
// Scoreboard bench for mux_1_3_deadlock_reporter with THRESHOLD = 8.
module tb_mux_1_3_deadlock_reporter;

  localparam int THR   = 8;
  localparam int CNT_W = 16;
  localparam int LIMIT = 40;

  typedef struct packed {
    logic [3:0]       cause;
    logic [CNT_W-1:0] cycles;
  } report_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mux_1_3_deadlock_reporter_if #(.CNT_W(CNT_W)) bus ();

  mux_1_3_deadlock_reporter #(
    .THRESHOLD(THR),
    .CNT_W    (CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int      n_vec = 0;
  int      n_bad = 0;
  int      n_xfer = 0;
  report_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pop and compare whenever a transfer will complete on the next edge.
  always @(negedge clock) begin
    if (!reset && bus.report_valid && bus.report_ready) begin
      n_xfer++;
      check("report_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        report_t e;
        e = sb.pop_front();
        check("report_cause", 32'(bus.report_cause), 32'(e.cause));
        check("report_cycles", 32'(bus.report_cycles), 32'(e.cycles));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Advance until report_valid is seen; n is the number of edges taken.
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.report_valid !== 1'b1 && n < LIMIT) begin
      step();
      n++;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.report_valid), 32'd0);
    check({tag, "_deadlock"}, 32'(bus.deadlock), 32'd0);
    check({tag, "_cause"}, 32'(bus.report_cause), 32'd0);
    check({tag, "_cycles"}, 32'(bus.report_cycles), 32'd0);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  int n;
  int xfer_exp = 0;

  initial begin
    bus.block           = 1'b0;
    bus.axis_block_sigs = 4'h0;
    bus.clear           = 1'b0;
    bus.report_ready    = 1'b0;
    #2;
    check_idle_outputs("reset_state");
    step(2);
    reset = 1'b0;
    step();

    // 1: reset mid-COUNT, then quiet input must never report.
    bus.block = 1'b1;
    bus.axis_block_sigs = 4'h3;
    step(4);
    reset = 1'b1;
    #1;
    check_idle_outputs("s1_reset");
    step(2);
    reset = 1'b0;
    bus.block = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check("s1_quiet_valid", 32'(bus.report_valid), 32'd0);
    end

    // 2: seven-cycle run falls short, next run needs a full eight.
    bus.block = 1'b1;
    bus.axis_block_sigs = 4'h2;
    for (int i = 0; i < 7; i++) begin
      step();
      check("s2_short_valid", 32'(bus.report_valid), 32'd0);
      check("s2_short_deadlock", 32'(bus.deadlock), 32'd0);
    end
    bus.block = 1'b0;
    step();
    check("s2_gap_deadlock", 32'(bus.deadlock), 32'd0);
    bus.report_ready = 1'b1;
    bus.block = 1'b1;
    sb.push_back('{cause: 4'h2, cycles: CNT_W'(THR)});
    xfer_exp++;
    wait_valid(n);
    check("s2_latency", 32'(n), 32'(THR));
    bus.block = 1'b0;
    step();
    check("s2_valid_drop", 32'(bus.report_valid), 32'd0);
    pulse_clear();
    check_idle_outputs("s2_after_clear");

    // 3: cause accumulates across the run, one-cycle valid with ready high.
    bus.block = 1'b1;
    sb.push_back('{cause: 4'b0101, cycles: CNT_W'(THR)});
    xfer_exp++;
    for (int i = 0; i < THR; i++) begin
      bus.axis_block_sigs = (i < 3) ? 4'b0001 : 4'b0100;
      step();
      check("s3_valid_timing", 32'(bus.report_valid), (i == THR - 1) ? 32'd1 : 32'd0);
    end
    check("s3_cause", 32'(bus.report_cause), 32'h5);
    check("s3_cycles", 32'(bus.report_cycles), 32'(THR));
    bus.block = 1'b0;
    bus.axis_block_sigs = 4'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("s3_valid_once", 32'(bus.report_valid), 32'd0);
      check("s3_deadlock_sticky", 32'(bus.deadlock), 32'd1);
    end
    pulse_clear();
    check("s3_clear_deadlock", 32'(bus.deadlock), 32'd0);

    // 4: backpressure holds the payload; clear in REPORT is ignored.
    bus.report_ready = 1'b0;
    bus.block = 1'b1;
    bus.axis_block_sigs = 4'b1000;
    sb.push_back('{cause: 4'b1000, cycles: CNT_W'(THR)});
    xfer_exp++;
    wait_valid(n);
    check("s4_latency", 32'(n), 32'(THR));
    for (int i = 0; i < 5; i++) begin
      bus.block = i[0];
      bus.axis_block_sigs = 4'($urandom_range(0, 15));
      bus.clear = (i == 2);
      step();
      check("s4_valid_held", 32'(bus.report_valid), 32'd1);
      check("s4_cause_frozen", 32'(bus.report_cause), 32'h8);
      check("s4_cycles_frozen", 32'(bus.report_cycles), 32'(THR));
    end
    bus.clear = 1'b0;
    bus.report_ready = 1'b1;
    step();
    check("s4_valid_after_xfer", 32'(bus.report_valid), 32'd0);
    check("s4_deadlock_hold", 32'(bus.deadlock), 32'd1);
    check("s4_cause_hold", 32'(bus.report_cause), 32'h8);

    // 5: clear in HOLD with block stuck high restarts a full run.
    bus.report_ready = 1'b0;
    bus.block = 1'b1;
    bus.axis_block_sigs = 4'b0010;
    step(2);
    check("s5_hold_deadlock", 32'(bus.deadlock), 32'd1);
    pulse_clear();
    check("s5_clear_deadlock", 32'(bus.deadlock), 32'd0);
    check("s5_clear_cause", 32'(bus.report_cause), 32'd0);
    sb.push_back('{cause: 4'b0010, cycles: CNT_W'(THR)});
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n++;
    end
    bus.clear = 1'b1;
    step();
    n++;
    bus.clear = 1'b0;
    while (bus.report_valid !== 1'b1 && n < LIMIT) begin
      step();
      n++;
    end
    check("s5_fresh_latency", 32'(n), 32'(THR));
    check("s5_fresh_deadlock", 32'(bus.deadlock), 32'd1);

    // 6: asynchronous reset between edges while in REPORT; report is lost.
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_valid", 32'(bus.report_valid), 32'd0);
    check("s6_async_deadlock", 32'(bus.deadlock), 32'd0);
    sb.delete();
    step();
    reset = 1'b0;
    bus.block = 1'b0;
    bus.report_ready = 1'b1;
    step();
    check_idle_outputs("s6_restart");
    bus.block = 1'b1;
    bus.axis_block_sigs = 4'b0110;
    sb.push_back('{cause: 4'b0110, cycles: CNT_W'(THR)});
    xfer_exp++;
    wait_valid(n);
    check("s6_relatency", 32'(n), 32'(THR));
    bus.block = 1'b0;
    step(2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("xfer_count", 32'(n_xfer), 32'(xfer_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_1_3_deadlock_reporter.md
# mux_1_3_deadlock_reporter

Downstream consumer of the `mux_1_3` HLS deadlock monitor's registered `block` output. It filters transient stalls by requiring `block` to stay high for THRESHOLD consecutive cycles. It accumulates which of the four AXI-Stream channels contributed to the stall, and presents a one-shot deadlock report over a valid/ready handshake. It also drives a sticky `deadlock` level that holds until software or a debug host clears it.

## Interface
- THRESHOLD, 1024: consecutive `block`-high cycles that declare a deadlock. Legal range is 2 to 2^CNT_W−1.
- CNT_W, 16: width of the run counter and of `report_cycles`.

- `clock`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `block`  in  1  registered block flag from the deadlock monitor.
- `axis_block_sigs`  in  4  per-channel AXIS block flags, the same bus that feeds the monitor.
- `clear`  in  1  single-cycle pulse that re-arms the block after a report.
- `report_valid`  out  1  a deadlock report is available.
- `report_ready`  in  1  the consumer accepts the report.
- `report_cause`  out  4  OR of `axis_block_sigs` over the qualifying stall run.
- `report_cycles`  out  CNT_W  run length at the moment of declaration (equals THRESHOLD).
- `deadlock`  out  1  sticky deadlock indication.

## Operation
- The FSM has four states: IDLE, COUNT, REPORT, HOLD.
- **IDLE**
  - run_cnt = 0 and cause_acc = 0.
  - If `block` = 1: run_cnt ← 1, cause_acc ← `axis_block_sigs`, go to COUNT.
- **COUNT**
  - If `block` = 0: go to IDLE, clearing run_cnt and cause_acc.
  - Else, if run_cnt = THRESHOLD−1:
    - load `report_cause` ← cause_acc | `axis_block_sigs`;
    - load `report_cycles` ← THRESHOLD;
    - go to REPORT.
  - Else: run_cnt ← run_cnt+1, cause_acc ← cause_acc | `axis_block_sigs`.
- **REPORT**
  - `report_valid` = 1 and `deadlock` = 1.
  - The payload is frozen and does not change while `report_valid` = 1.
  - On `report_valid` & `report_ready`: go to HOLD.
  - `block` and `clear` are ignored in this state.
- **HOLD**
  - `deadlock` = 1 and `report_valid` = 0.
  - `report_cause` and `report_cycles` keep their values.
  - On `clear` = 1: go to IDLE and zero the payload registers.
  - If `block` is still high after `clear`, a new run starts from the IDLE rule on the following cycle. No cycles carry over from the previous run.
- `clear` has no effect in IDLE or COUNT.
- A `block` glitch of one low cycle in COUNT fully restarts the run. There is no hysteresis.
- `deadlock` is high in REPORT and HOLD, and low otherwise.

## Timing
- **Reset values** (asynchronous assertion, all outputs):
  - state = IDLE;
  - `report_valid` = 0, `deadlock` = 0;
  - `report_cause` = 4'h0, `report_cycles` = 0;
  - run_cnt = 0, cause_acc = 0.
- **Reset mid-operation:** asserting `reset` in any state drops `report_valid` and `deadlock` immediately, without waiting for a clock edge. The report is lost and no handshake completes.
- **Declaration latency:** if `block` is first high at edge k and stays high, `report_valid` and `deadlock` rise after edge k+THRESHOLD−1. That is THRESHOLD sampled high cycles.
- **Registered outputs:** all outputs are registered, with no combinational path from input to output.
- **Handshake:**
  - `report_valid` is held until accepted.
  - `report_ready` may be high before `report_valid` rises. The transfer then completes on the first REPORT cycle.
  - `report_valid` falls on the edge after the transfer.
- **Clear latency:** `clear` sampled high in HOLD makes `deadlock` low after that edge.
- **Counter bounds:** run_cnt never exceeds THRESHOLD−1, so there is no wrap-around. Width is CNT_W bits, unsigned.

## Test plan
All scenarios use THRESHOLD = 8, CNT_W = 16.
1. Hold `reset` high mid-COUNT, then release. Required: all outputs read 0; no report appears while `block` = 0.
2. `block` high for 7 cycles, then low. Required: `report_valid` and `deadlock` never assert; state returns to IDLE; the next 8-cycle run still needs a full 8 cycles.
3. `block` high for 8 cycles, with `axis_block_sigs` = 4'b0001 then 4'b0100 mid-run, and `report_ready` = 1. Required:
   - `report_valid` is high for exactly 1 cycle, 8 samples after the first high sample;
   - `report_cause` = 4'b0101 and `report_cycles` = 8;
   - `deadlock` stays high afterwards.
4. Trigger a report with `report_ready` = 0 for 5 cycles, toggling `block` and `axis_block_sigs`, then raise `report_ready`. Required: `report_valid` and the payload stay stable for all 5 cycles; the transfer happens on the `report_ready` edge.
5. Pulse `clear` in HOLD with `block` = 1 continuously. Required:
   - `deadlock` falls the next cycle;
   - a fresh report occurs 8 samples later;
   - a `clear` pulse during REPORT or COUNT has no effect.
6. Assert `reset` asynchronously during REPORT, between clock edges. Required: `report_valid` and `deadlock` drop before the next edge; the block restarts cleanly in IDLE.
